merge_data_stream: RTL and testbench

//  Successor to the fixed byte-to-sample merger in the FM demodulator front end.

---
 rtl/merge_data_stream_pkg.sv | 29 ++
 rtl/merge_data_stream_sync_fifo.sv | 68 ++++++
 rtl/merge_data_stream.sv | 121 ++++++++++++
 tb/tb_merge_data_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_data_stream_pkg.sv
// Shared definitions for the byte-to-word merger and its output FIFO.
//  BYTE_W          width of one incoming UART byte
//  clog2()         ceiling log2, usable in constant expressions
//  bytes_per_word  number of bytes that make up one NCH*WIDTH word
//  count_width     width of a counter that spans 0..nb-1 (at least 1 bit)
package merge_data_stream_pkg;

    localparam int BYTE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bytes_per_word(input int width, input int nch);
        return (width * nch) / BYTE_W;
    endfunction

    function automatic int count_width(input int nb);
        return (nb > 1) ? clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/merge_data_stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//  clk        rising-edge clock
//  rst        asynchronous reset, active-low
//  push       write push_data this edge (ignored when full unless pop)
//  push_data  word to store
//  pop        remove the head word this edge (ignored when empty)
//  pop_data   head word, valid while empty=0; forced to 0 when empty
//  full       DEPTH words stored
//  empty      no word stored
//  level      occupancy 0..DEPTH
module merge_data_stream_sync_fifo
    import merge_data_stream_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);

    // When full, a push is still taken if the head leaves in the same edge:
    // the freed slot is the one the write pointer addresses.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_data_stream.sv
// Packs a stream of UART bytes into words of NCH components, WIDTH bits each
// (component k = data_o[k*WIDTH +: WIDTH]), and buffers finished words in a
// small FWFT FIFO towards the demodulator.
//  clk           rising-edge clock
//  rst           asynchronous reset, active-low
//  data_uart_i   received byte
//  byte_valid_i  data_uart_i valid this cycle
//  msb_first_i   1: first byte lands in the MSBs; 0: first byte lands in bits[7:0]
//  sync_i        drop the partial word, next byte is byte 0
//  ready_i       downstream accepts data_o
//  data_o        head word of the FIFO (0 when empty)
//  valid_o       FIFO not empty
//  overflow_o    sticky: a completed word was dropped because the FIFO was full
//  level_o       FIFO occupancy
//
// Output handshake: a word moves when valid_o and ready_i are both high at a
// rising edge. valid_o never depends on ready_i; data_o holds while valid_o=1
// and ready_i=0; the next word (or valid_o=0) shows after the transfer edge.
module merge_data_stream
    import merge_data_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_uart_i,
    input  logic                   byte_valid_i,
    input  logic                   msb_first_i,
    input  logic                   sync_i,
    input  logic                   ready_i,
    output logic [NCH*WIDTH-1:0]   data_o,
    output logic                   valid_o,
    output logic                   overflow_o,
    output logic [clog2(DEPTH):0]  level_o
);

    localparam int W     = NCH * WIDTH;
    localparam int NB    = bytes_per_word(WIDTH, NCH);
    localparam int CNT_W = count_width(NB);

    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [W-1:0]     shift_q;
    logic [W-1:0]     shift_base;
    logic [W-1:0]     shift_next;
    logic [W-1:0]     push_data_q;
    logic             push_valid_q;
    logic             msb_mode_q;
    logic             mode_eff;
    logic             word_last;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    // A sync in the same cycle as a byte makes that byte byte 0 of a fresh word,
    // so the packing logic works from a cleared base in that case.
    always_comb begin
        cnt_base   = sync_i ? '0 : byte_cnt_q;
        shift_base = sync_i ? '0 : shift_q;
        // Byte order is latched at byte 0 and held for the rest of the word.
        mode_eff   = (cnt_base == '0) ? msb_first_i : msb_mode_q;
        word_last  = (cnt_base == CNT_W'(NB - 1));
        cnt_next   = word_last ? '0 : cnt_base + CNT_W'(1);
        if (mode_eff) begin
            shift_next = (shift_base << BYTE_W) | W'(data_uart_i);
        end else begin
            shift_next = (shift_base >> BYTE_W) | (W'(data_uart_i) << (W - BYTE_W));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            msb_mode_q   <= 1'b0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (byte_valid_i) begin
                byte_cnt_q <= cnt_next;
                shift_q    <= shift_next;
                msb_mode_q <= mode_eff;
            end else if (sync_i) begin
                byte_cnt_q <= '0;
                shift_q    <= '0;
            end
            // The push stage is independent of sync: a word completed on the
            // previous edge still reaches the FIFO.
            push_valid_q <= byte_valid_i & word_last;
            if (byte_valid_i & word_last) begin
                push_data_q <= shift_next;
            end
            if (push_valid_q & fifo_full & ~fifo_pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign fifo_pop = ready_i & ~fifo_empty;
    assign valid_o  = ~fifo_empty;

    merge_data_stream_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid_q),
        .push_data (push_data_q),
        .pop       (fifo_pop),
        .pop_data  (data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_o)
    );

endmodule

// File: tb/tb_merge_data_stream.sv
module tb_merge_data_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  data_uart_i;
    logic        byte_valid_i;
    logic        byte_valid2_i;
    logic        msb_first_i;
    logic        sync_i;
    logic        ready_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        overflow_o;
    logic [2:0]  level_o;
    logic [23:0] data2_o;
    logic        valid2_o;
    logic        overflow2_o;
    logic [2:0]  level2_o;

    int errors;
    int checks;

    logic [31:0] exp_q[$];
    logic [23:0] exp2_q[$];

    logic [31:0] words [5];

    merge_data_stream #(.WIDTH(16), .NCH(2), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_uart_i  (data_uart_i),
        .byte_valid_i (byte_valid_i),
        .msb_first_i  (msb_first_i),
        .sync_i       (sync_i),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .overflow_o   (overflow_o),
        .level_o      (level_o)
    );

    merge_data_stream #(.WIDTH(24), .NCH(1), .DEPTH(4)) dut24 (
        .clk          (clk),
        .rst          (rst),
        .data_uart_i  (data_uart_i),
        .byte_valid_i (byte_valid2_i),
        .msb_first_i  (msb_first_i),
        .sync_i       (sync_i),
        .ready_i      (ready_i),
        .data_o       (data2_o),
        .valid_o      (valid2_o),
        .overflow_o   (overflow2_o),
        .level_o      (level2_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drivers
    task automatic put_byte(input logic [7:0] b, input logic msb, input logic s);
        data_uart_i  = b;
        msb_first_i  = msb;
        sync_i       = s;
        byte_valid_i = 1'b1;
        cyc();
        byte_valid_i = 1'b0;
        sync_i       = 1'b0;
    endtask

    task automatic put_byte24(input logic [7:0] b);
        data_uart_i   = b;
        msb_first_i   = 1'b1;
        byte_valid2_i = 1'b1;
        cyc();
        byte_valid2_i = 1'b0;
    endtask

    task automatic put_word_msb(input logic [31:0] w);
        for (int j = 0; j < 4; j++) begin
            put_byte(w[31-8*j -: 8], 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    // Scoreboard monitors: compare whenever a word transfers.
    always @(negedge clk) begin
        if (rst && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out32_unexpected: got %h expected none", data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL out32_data: got %h expected %h", data_o, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && valid2_o && ready_i) begin
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL out24_unexpected: got %h expected none", data2_o);
            end else begin
                logic [23:0] e;
                e = exp2_q.pop_front();
                if (data2_o !== e) begin
                    errors++;
                    $display("FAIL out24_data: got %h expected %h", data2_o, e);
                end
            end
        end
    end

    initial begin
        int budget;
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        data_uart_i   = 8'h00;
        byte_valid_i  = 1'b0;
        byte_valid2_i = 1'b0;
        msb_first_i   = 1'b1;
        sync_i        = 1'b0;
        ready_i       = 1'b1;
        words[0] = 32'h10111213;
        words[1] = 32'h20212223;
        words[2] = 32'h30313233;
        words[3] = 32'h40414243;
        words[4] = 32'h50515253;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_level", {29'd0, level_o}, 32'd0);
        check("reset_overflow", {31'd0, overflow_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        rst = 1'b1;
        cyc();

        // T1: MSB-first, latency and one-cycle valid pulse
        exp_q.push_back(32'h12345678);
        put_byte(8'h12, 1'b1, 1'b0);
        put_byte(8'h34, 1'b1, 1'b0);
        put_byte(8'h56, 1'b1, 1'b0);
        put_byte(8'h78, 1'b1, 1'b0);
        check("t1_valid_before", {31'd0, valid_o}, 32'd0);
        cyc();
        check("t1_valid_latency", {31'd0, valid_o}, 32'd1);
        check("t1_data", data_o, 32'h12345678);
        cyc();
        check("t1_valid_drop", {31'd0, valid_o}, 32'd0);
        cyc();
        check("t1_empty_ready_level", {29'd0, level_o}, 32'd0);

        // T2: LSB-first, then mode toggled after byte 0
        exp_q.push_back(32'h78563412);
        put_byte(8'h12, 1'b0, 1'b0);
        put_byte(8'h34, 1'b0, 1'b0);
        put_byte(8'h56, 1'b0, 1'b0);
        put_byte(8'h78, 1'b0, 1'b0);
        exp_q.push_back(32'h78563412);
        put_byte(8'h12, 1'b0, 1'b0);
        put_byte(8'h34, 1'b1, 1'b0);
        put_byte(8'h56, 1'b1, 1'b0);
        put_byte(8'h78, 1'b1, 1'b0);
        repeat (3) cyc();

        // T3: backpressure, fifth word lost
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back(words[k]);
            put_word_msb(words[k]);
        end
        cyc();
        cyc();
        check("t3_level_full", {29'd0, level_o}, 32'd4);
        check("t3_overflow", {31'd0, overflow_o}, 32'd1);
        check("t3_head_stable", data_o, words[0]);
        ready_i = 1'b1;
        repeat (8) cyc();
        check("t3_level_drained", {29'd0, level_o}, 32'd0);
        check("t3_overflow_sticky", {31'd0, overflow_o}, 32'd1);

        do_reset();
        check("rst_overflow_clear", {31'd0, overflow_o}, 32'd0);

        // T4: push and pop in the same edge while full
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(words[k]);
        end
        for (int k = 0; k < 4; k++) begin
            put_word_msb(words[k]);
        end
        cyc();
        cyc();
        check("t4_level_full", {29'd0, level_o}, 32'd4);
        put_word_msb(words[4]);
        ready_i = 1'b1;
        cyc();
        check("t4_level_hold", {29'd0, level_o}, 32'd4);
        check("t4_no_overflow", {31'd0, overflow_o}, 32'd0);
        repeat (8) cyc();
        check("t4_level_drained", {29'd0, level_o}, 32'd0);
        check("t4_no_overflow_end", {31'd0, overflow_o}, 32'd0);

        // T5: resync with a byte in the same cycle
        exp_q.push_back(32'h11223344);
        put_byte(8'hAA, 1'b1, 1'b0);
        put_byte(8'hBB, 1'b1, 1'b0);
        put_byte(8'h11, 1'b1, 1'b1);
        put_byte(8'h22, 1'b1, 1'b0);
        put_byte(8'h33, 1'b1, 1'b0);
        put_byte(8'h44, 1'b1, 1'b0);
        repeat (4) cyc();
        check("t5_level", {29'd0, level_o}, 32'd0);

        // T6: reset mid-word, then a clean word
        put_byte(8'h01, 1'b1, 1'b0);
        put_byte(8'h02, 1'b1, 1'b0);
        rst = 1'b0;
        #2;
        check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
        check("t6_rst_level", {29'd0, level_o}, 32'd0);
        check("t6_rst_data", data_o, 32'd0);
        check("t6_rst_overflow", {31'd0, overflow_o}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        exp_q.push_back(32'h01020304);
        put_byte(8'h01, 1'b1, 1'b0);
        put_byte(8'h02, 1'b1, 1'b0);
        put_byte(8'h03, 1'b1, 1'b0);
        put_byte(8'h04, 1'b1, 1'b0);
        cyc();
        check("t6_data", data_o, 32'h01020304);

        // T6: 24-bit single-component instance
        exp2_q.push_back(24'h0A0B0C);
        put_byte24(8'h0A);
        put_byte24(8'h0B);
        put_byte24(8'h0C);
        check("t6w24_valid_before", {31'd0, valid2_o}, 32'd0);
        cyc();
        check("t6w24_valid", {31'd0, valid2_o}, 32'd1);
        check("t6w24_data", {8'd0, data2_o}, 32'h000A0B0C);

        budget = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && budget < 200) begin
            cyc();
            budget++;
        end
        check("drain_q32", exp_q.size(), 32'd0);
        check("drain_q24", exp2_q.size(), 32'd0);
        check("w24_overflow", {31'd0, overflow2_o}, 32'd0);
        check("w24_level", {29'd0, level2_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
